// File: rtl/yc_line_sequencer.sv
// yc_line_sequencer: per-line burst/chroma windows, PAL alternation and vsync-applied subcarrier config
module yc_line_sequencer #(
  parameter int PHASE_W = 40,
  parameter int CNT_W = 10,
  parameter int BURST_START = 40,
  parameter int BURST_LEN = 200,
  parameter logic [PHASE_W-1:0] RST_PHASE_INC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_phase_inc,
  input  logic               cfg_pal,
  output logic [PHASE_W-1:0] phase_inc_o,
  output logic               pal_en_o,
  output logic               pal_flip_o,
  output logic               burst_en_o,
  output logic               chroma_en_o,
  output logic [10:0]        line_cnt_o
);
  typedef enum logic [1:0] {SYNC, WAIT, BURST, ACTIVE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] BURST_GO = CNT_W'(BURST_START - 1);
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(BURST_START + BURST_LEN - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic hsync_d, vsync_d;
  logic [PHASE_W-1:0] shadow_inc;
  logic shadow_pal, pending;
  wire h_rise = hsync & ~hsync_d;
  wire h_fall = ~hsync & hsync_d;
  wire v_rise = vsync & ~vsync_d;
  wire xfer = cfg_valid & cfg_ready;
  wire pending_n = xfer | (pending & ~v_rise);
  // line window FSM: the pixel counter runs from hsync fall and both window edges are decoded from it
  always_comb begin
    state_n = state;
    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    case (state)
      SYNC: begin
        cnt_n = '0;
        if (h_fall) state_n = WAIT;
      end
      WAIT: if (cnt == BURST_GO) state_n = BURST;
      BURST: if (cnt == BURST_END) state_n = ACTIVE;
      default: state_n = state;
    endcase
    if (h_rise) begin
      state_n = SYNC;
      cnt_n = '0;
    end
  end
  // sync edge history, FSM state and registered window outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_d <= 1'b0;
      vsync_d <= 1'b0;
      state <= SYNC;
      cnt <= '0;
      burst_en_o <= 1'b0;
      chroma_en_o <= 1'b0;
    end else begin
      hsync_d <= hsync;
      vsync_d <= vsync;
      state <= state_n;
      cnt <= cnt_n;
      burst_en_o <= state_n == BURST;
      chroma_en_o <= state_n == ACTIVE;
    end
  end
  // line count and PAL alternation; a mode switch can only happen on vsync rise, which also clears the flip
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_cnt_o <= '0;
      pal_flip_o <= 1'b0;
    end else begin
      line_cnt_o <= v_rise ? '0 : (h_rise && line_cnt_o != 11'h7ff) ? line_cnt_o + 1'b1 : line_cnt_o;
      pal_flip_o <= ~v_rise & pal_en_o & (pal_flip_o ^ h_rise);
    end
  end
  // config handshake: one shadowed transfer in flight, committed to the modulator only at frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_inc <= '0;
      shadow_pal <= 1'b0;
      pending <= 1'b0;
      cfg_ready <= 1'b1;
      phase_inc_o <= RST_PHASE_INC;
      pal_en_o <= 1'b0;
    end else begin
      if (v_rise && pending) begin
        phase_inc_o <= shadow_inc;
        pal_en_o <= shadow_pal;
      end
      if (xfer) begin
        shadow_inc <= cfg_phase_inc;
        shadow_pal <= cfg_pal;
      end
      pending <= pending_n;
      cfg_ready <= ~pending_n;
    end
  end
endmodule

// File: tb/tb_yc_line_sequencer.sv
// tb_yc_line_sequencer: directed scenarios plus randomized traffic against a line-position reference model
module tb_yc_line_sequencer;
  localparam int PW = 40;
  localparam int BS = 40;
  localparam int BL = 200;
  logic clk = 1'b0, reset = 1'b0, hsync = 1'b0, vsync = 1'b0, cfg_valid = 1'b0, cfg_pal = 1'b0;
  logic [PW-1:0] cfg_phase_inc = '0;
  logic cfg_ready, pal_en_o, pal_flip_o, burst_en_o, chroma_en_o;
  logic [PW-1:0] phase_inc_o;
  logic [10:0] line_cnt_o;
  int checks = 0, failures = 0;
  bit m_ph, m_pv, m_alive, m_flip, m_pal, m_pend, m_sh_pal;
  int m_k, m_lines;
  logic [PW-1:0] m_inc, m_sh_inc;

  yc_line_sequencer dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_phase_inc(cfg_phase_inc), .cfg_pal(cfg_pal), .phase_inc_o(phase_inc_o), .pal_en_o(pal_en_o),
    .pal_flip_o(pal_flip_o), .burst_en_o(burst_en_o), .chroma_en_o(chroma_en_o), .line_cnt_o(line_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ph = 0; m_pv = 0; m_alive = 0; m_k = 0; m_lines = 0; m_flip = 0;
    m_pal = 0; m_pend = 0; m_sh_pal = 0; m_inc = '0; m_sh_inc = '0;
  endfunction

  function automatic void model_edge();
    bit hr, hf, vr, xfer;
    hr = hsync && !m_ph;
    hf = !hsync && m_ph;
    vr = vsync && !m_pv;
    xfer = cfg_valid && !m_pend;
    if (hr) m_alive = 0;
    else if (hf) begin m_alive = 1; m_k = 0; end
    else if (m_alive && m_k < 100000) m_k++;
    m_lines = vr ? 0 : hr ? (m_lines < 2047 ? m_lines + 1 : 2047) : m_lines;
    m_flip = vr ? 0 : (m_pal && hr) ? !m_flip : m_flip;
    if (vr && m_pend) begin m_inc = m_sh_inc; m_pal = m_sh_pal; m_pend = 0; end
    if (xfer) begin m_sh_inc = cfg_phase_inc; m_sh_pal = cfg_pal; m_pend = 1; end
    m_ph = hsync;
    m_pv = vsync;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    tick(); tick();
    checks += 7;
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    if (phase_inc_o !== '0) begin failures++; $display("FAIL reset_phase got=%h exp=0", phase_inc_o); end
    if (pal_en_o !== 1'b0) begin failures++; $display("FAIL reset_pal got=%b exp=0", pal_en_o); end
    if (pal_flip_o !== 1'b0) begin failures++; $display("FAIL reset_flip got=%b exp=0", pal_flip_o); end
    if (burst_en_o !== 1'b0) begin failures++; $display("FAIL reset_burst got=%b exp=0", burst_en_o); end
    if (chroma_en_o !== 1'b0) begin failures++; $display("FAIL reset_chroma got=%b exp=0", chroma_en_o); end
    if (line_cnt_o !== 11'd0) begin failures++; $display("FAIL reset_lines got=%0d exp=0", line_cnt_o); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_burst_window();
    hsync = 1'b1;
    repeat (10) tick();
    hsync = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      checks++;
      if ({burst_en_o, chroma_en_o} !== {n >= BS + 1 && n <= BS + BL, n >= BS + BL + 1}) begin
        failures++;
        $display("FAIL window clk=%0d got burst=%b chroma=%b exp burst=%b chroma=%b", n, burst_en_o, chroma_en_o,
                 n >= BS + 1 && n <= BS + BL, n >= BS + BL + 1);
      end
    end
  endtask

  task automatic test_early_rise();
    hsync = 1'b1;
    repeat (10) tick();
    hsync = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      if (n == 100) hsync = 1'b1;
      tick();
      if (n == 99 || n >= 100) begin
        checks++;
        if ({burst_en_o, chroma_en_o} !== {n == 99, 1'b0}) begin
          failures++;
          $display("FAIL early_rise clk=%0d got burst=%b chroma=%b exp burst=%b chroma=0", n, burst_en_o, chroma_en_o, n == 99);
        end
      end
    end
    hsync = 1'b0;
    tick();
  endtask

  task automatic test_cfg_apply();
    cfg_valid = 1'b1; cfg_phase_inc = 40'h0123456789; cfg_pal = 1'b1;
    tick();
    cfg_phase_inc = 40'hffffffffff; cfg_pal = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if ({cfg_ready, pal_en_o, phase_inc_o} !== {1'b0, 1'b0, 40'h0}) begin
        failures++;
        $display("FAIL cfg_hold got ready=%b pal=%b inc=%h exp ready=0 pal=0 inc=0", cfg_ready, pal_en_o, phase_inc_o);
      end
    end
    cfg_valid = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    checks++;
    if ({cfg_ready, pal_en_o, phase_inc_o} !== {1'b1, 1'b1, 40'h0123456789}) begin
      failures++;
      $display("FAIL cfg_apply got ready=%b pal=%b inc=%h exp ready=1 pal=1 inc=0123456789", cfg_ready, pal_en_o, phase_inc_o);
    end
    vsync = 1'b0;
    tick();
  endtask

  task automatic test_pal_flip();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({pal_flip_o, line_cnt_o} !== {1'b0, 11'd0}) begin
      failures++;
      $display("FAIL flip_start got flip=%b lines=%0d exp flip=0 lines=0", pal_flip_o, line_cnt_o);
    end
    for (int p = 1; p <= 4; p++) begin
      hsync = 1'b1;
      tick();
      checks++;
      if (pal_flip_o !== 1'(p % 2)) begin
        failures++;
        $display("FAIL flip_seq pulse=%0d got=%b exp=%b", p, pal_flip_o, 1'(p % 2));
      end
      tick(); tick();
      hsync = 1'b0;
      repeat (5) tick();
    end
    checks++;
    if (line_cnt_o !== 11'd4) begin failures++; $display("FAIL flip_lines got=%0d exp=4", line_cnt_o); end
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({pal_flip_o, line_cnt_o} !== {1'b0, 11'd0}) begin
      failures++;
      $display("FAIL flip_vsync got flip=%b lines=%0d exp flip=0 lines=0", pal_flip_o, line_cnt_o);
    end
    tick();
  endtask

  task automatic test_cfg_same_vsync();
    cfg_valid = 1'b1; cfg_phase_inc = 40'habcdef0123; cfg_pal = 1'b0; vsync = 1'b1;
    tick();
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_ready, pal_en_o, phase_inc_o} !== {1'b0, 1'b1, 40'h0123456789}) begin
      failures++;
      $display("FAIL same_vsync_hold got ready=%b pal=%b inc=%h exp ready=0 pal=1 inc=0123456789", cfg_ready, pal_en_o, phase_inc_o);
    end
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({cfg_ready, pal_en_o, pal_flip_o, phase_inc_o} !== {1'b1, 1'b0, 1'b0, 40'habcdef0123}) begin
      failures++;
      $display("FAIL same_vsync_apply got ready=%b pal=%b flip=%b inc=%h exp ready=1 pal=0 flip=0 inc=abcdef0123",
               cfg_ready, pal_en_o, pal_flip_o, phase_inc_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    cfg_valid = 1'b1; cfg_phase_inc = 40'h5555aaaa55; cfg_pal = 1'b1;
    tick();
    cfg_valid = 1'b0;
    hsync = 1'b1;
    repeat (3) tick();
    hsync = 1'b0;
    repeat (50) tick();
    checks++;
    if ({burst_en_o, cfg_ready} !== 2'b10) begin
      failures++;
      $display("FAIL pre_reset got burst=%b ready=%b exp burst=1 ready=0", burst_en_o, cfg_ready);
    end
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({cfg_ready, phase_inc_o, pal_en_o, pal_flip_o, burst_en_o, chroma_en_o, line_cnt_o} !== {1'b1, 40'h0, 4'b0, 11'd0}) begin
      failures++;
      $display("FAIL async_reset got ready=%b inc=%h pal=%b flip=%b burst=%b chroma=%b lines=%0d exp ready=1 rest=0",
               cfg_ready, phase_inc_o, pal_en_o, pal_flip_o, burst_en_o, chroma_en_o, line_cnt_o);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    checks++;
    if ({cfg_ready, pal_en_o, phase_inc_o} !== {1'b1, 1'b0, 40'h0}) begin
      failures++;
      $display("FAIL reset_discard got ready=%b pal=%b inc=%h exp ready=1 pal=0 inc=0", cfg_ready, pal_en_o, phase_inc_o);
    end
    tick();
  endtask

  task automatic test_line_saturation();
    for (int p = 0; p < 2050; p++) begin
      hsync = 1'b1; tick();
      hsync = 1'b0; tick();
    end
    checks++;
    if (line_cnt_o !== 11'd2047) begin failures++; $display("FAIL line_sat got=%0d exp=2047", line_cnt_o); end
    hsync = 1'b1; vsync = 1'b1;
    tick();
    checks++;
    if (line_cnt_o !== 11'd0) begin failures++; $display("FAIL vsync_wins got=%0d exp=0", line_cnt_o); end
    hsync = 1'b0; vsync = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [63:0] r;
    for (int l = 0; l < 24; l++) begin
      int hi, lo;
      hi = $urandom_range(1, 8);
      lo = $urandom_range(20, 400);
      for (int c = 0; c < hi + lo; c++) begin
        hsync = c < hi;
        if ($urandom_range(0, 299) == 0) vsync = ~vsync;
        cfg_valid = $urandom_range(0, 7) == 0;
        r = {$urandom(), $urandom()};
        cfg_phase_inc = r[PW-1:0];
        cfg_pal = 1'($urandom());
        tick();
        checks++;
        if ({cfg_ready, phase_inc_o, pal_en_o, pal_flip_o, burst_en_o, chroma_en_o, line_cnt_o} !==
            {!m_pend, m_inc, m_pal, m_flip, m_alive && m_k >= BS && m_k < BS + BL, m_alive && m_k >= BS + BL, 11'(m_lines)}) begin
          failures++;
          $display("FAIL random line=%0d clk=%0d got ready=%b inc=%h pal=%b flip=%b burst=%b chroma=%b lines=%0d exp ready=%b inc=%h pal=%b flip=%b burst=%b chroma=%b lines=%0d",
                   l, c, cfg_ready, phase_inc_o, pal_en_o, pal_flip_o, burst_en_o, chroma_en_o, line_cnt_o,
                   !m_pend, m_inc, m_pal, m_flip, m_alive && m_k >= BS && m_k < BS + BL, m_alive && m_k >= BS + BL, m_lines);
        end
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_burst_window();
    test_early_rise();
    test_cfg_apply();
    test_pal_flip();
    test_cfg_same_vsync();
    test_reset_mid();
    test_line_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
